// File: rtl/tdp_ram_arbiter.sv
// tdp_ram_arbiter: request/grant front-end for a true dual-port RAM.
// Two initiator ports (A, B) share one storage array.
// A same-address access pair that includes a write is a collision. A
// round-robin grant serialises it, so one address is never written twice
// in the same edge. Reads return registered data one cycle after acceptance.
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   req_x, we_x, addr_x, wdata_x   port x request (x = a, b)
//   gnt_x                          combinational grant; accept = req_x & gnt_x
//   rvalid_x, rdata_x              one-cycle read-data pulse; rdata held otherwise
//   coll_cnt                       saturating count of collision cycles

// Per-port read response register. rdata holds its value between reads.
module tdp_ram_rsp #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rd_en_i,
  input  logic [WIDTH-1:0] rd_word_i,
  output logic             rvalid_o,
  output logic [WIDTH-1:0] rdata_o
);
  logic             rvalid_q;
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rd_en_i;
      if (rd_en_i) rdata_q <= rd_word_i;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
endmodule

module tdp_ram_arbiter #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [WIDTH-1:0]  wdata_a,
  output logic              gnt_a,
  output logic              rvalid_a,
  output logic [WIDTH-1:0]  rdata_a,
  input  logic              req_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [WIDTH-1:0]  wdata_b,
  output logic              gnt_b,
  output logic              rvalid_b,
  output logic [WIDTH-1:0]  rdata_b,
  output logic [CNT_W-1:0]  coll_cnt
);
  localparam int NP = 2;

  typedef struct packed {
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  wdata;
  } req_t;

  req_t [NP-1:0]            rq;
  logic [NP-1:0]            gnt, acc;
  logic [NP-1:0]            rvalid;
  logic [NP-1:0][WIDTH-1:0] rword, rdata;

  logic             coll;
  logic             rr_q, rr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] mem_q [DEPTH];

  assign rq[0] = '{req: req_a, we: we_a, addr: addr_a, wdata: wdata_a};
  assign rq[1] = '{req: req_b, we: we_b, addr: addr_b, wdata: wdata_b};

  // Read-read to one address is harmless; only write-involved pairs collide.
  assign coll = rq[0].req & rq[1].req & (rq[0].addr == rq[1].addr) &
                (rq[0].we | rq[1].we);

  // Grants are suppressed during reset so nothing is accepted while rst_n is low.
  always_comb begin
    gnt = '0;
    if (rst_n) begin
      if (coll) gnt = rr_q ? 2'b10 : 2'b01;
      else      gnt = {rq[1].req, rq[0].req};
    end
  end

  assign acc = gnt & {rq[1].req, rq[0].req};

  // Toggling on every collision hands the next one to the loser, which bounds
  // the wait of each port to one cycle under continuous collisions.
  always_comb begin
    rr_d  = rr_q;
    cnt_d = cnt_q;
    if (coll) begin
      rr_d = ~rr_q;
      if (!(&cnt_q)) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      rr_q  <= rr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage is not reset. Two accepted writes in one edge always target
  // different addresses because same-address writes are serialised.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NP; p++) begin
      if (acc[p] && rq[p].we) mem_q[rq[p].addr] <= rq[p].wdata;
    end
  end

  for (genvar p = 0; p < NP; p++) begin : g_port
    assign rword[p] = mem_q[rq[p].addr];

    tdp_ram_rsp #(.WIDTH(WIDTH)) u_rsp (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_en_i   (acc[p] & ~rq[p].we),
      .rd_word_i (rword[p]),
      .rvalid_o  (rvalid[p]),
      .rdata_o   (rdata[p])
    );
  end

  assign gnt_a    = gnt[0];
  assign gnt_b    = gnt[1];
  assign rvalid_a = rvalid[0];
  assign rvalid_b = rvalid[1];
  assign rdata_a  = rdata[0];
  assign rdata_b  = rdata[1];
  assign coll_cnt = cnt_q;
endmodule

// File: tb/tb_tdp_ram_arbiter.sv
module tb_tdp_ram_arbiter;
  localparam int WIDTH = 8;
  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int CW    = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
  logic [AW-1:0]    addr_a = '0, addr_b = '0;
  logic [WIDTH-1:0] wdata_a = '0, wdata_b = '0;
  logic             gnt_a, gnt_b, rvalid_a, rvalid_b;
  logic [WIDTH-1:0] rdata_a, rdata_b;
  logic [CW-1:0]    coll_cnt;

  tdp_ram_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .gnt_a(gnt_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_b(gnt_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b),
    .coll_cnt(coll_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model
  logic [WIDTH-1:0] m_mem [DEPTH];
  logic             m_rr = 1'b0;
  logic [CW-1:0]    m_cnt = '0;
  logic [WIDTH-1:0] m_last_a = '0, m_last_b = '0;
  logic [WIDTH-1:0] q_a [$];
  logic [WIDTH-1:0] q_b [$];
  logic             eg_a = 1'b0, eg_b = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic ra, input logic wa, input logic [AW-1:0] aa,
                       input logic [WIDTH-1:0] da, input logic rb, input logic wb,
                       input logic [AW-1:0] ab, input logic [WIDTH-1:0] db);
    req_a = ra; we_a = wa; addr_a = aa; wdata_a = da;
    req_b = rb; we_b = wb; addr_b = ab; wdata_b = db;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  // Called just after a negedge with inputs driven; ends at the posedge.
  task automatic step_edge();
    logic coll;
    #1;
    coll = req_a && req_b && (addr_a == addr_b) && (we_a || we_b);
    eg_a = req_a && (!coll || !m_rr);
    eg_b = req_b && (!coll || m_rr);
    chk("gnt_a", gnt_a, eg_a);
    chk("gnt_b", gnt_b, eg_b);
    @(posedge clk);
    if (eg_a && !we_a) q_a.push_back(m_mem[addr_a]);
    if (eg_b && !we_b) q_b.push_back(m_mem[addr_b]);
    if (eg_a && we_a) m_mem[addr_a] = wdata_a;
    if (eg_b && we_b) m_mem[addr_b] = wdata_b;
    if (coll) begin
      m_rr = ~m_rr;
      if (m_cnt != '1) m_cnt++;
    end
  endtask

  task automatic step_check();
    @(negedge clk);
    chk("rvalid_a", rvalid_a, q_a.size() > 0);
    if (q_a.size() > 0) begin
      m_last_a = q_a.pop_front();
      chk("rdata_a", rdata_a, m_last_a);
    end else chk("rdata_a_hold", rdata_a, m_last_a);
    chk("rvalid_b", rvalid_b, q_b.size() > 0);
    if (q_b.size() > 0) begin
      m_last_b = q_b.pop_front();
      chk("rdata_b", rdata_b, m_last_b);
    end else chk("rdata_b_hold", rdata_b, m_last_b);
    chk("coll_cnt", coll_cnt, m_cnt);
  endtask

  task automatic step();
    step_edge();
    step_check();
  endtask

  task automatic clr_model();
    q_a.delete(); q_b.delete();
    m_rr = 1'b0; m_cnt = '0; m_last_a = '0; m_last_b = '0;
  endtask

  // Entered at a negedge; requests held high to show grants are blocked.
  task automatic do_reset();
    rst_n = 1'b0;
    clr_model();
    drive(1'b1, 1'b0, 6'd1, '0, 1'b1, 1'b1, 6'd1, '0);
    #2;
    chk("rst_gnt_a", gnt_a, 1'b0);
    chk("rst_gnt_b", gnt_b, 1'b0);
    chk("rst_rvalid_a", rvalid_a, 1'b0);
    chk("rst_rvalid_b", rvalid_b, 1'b0);
    chk("rst_cnt", coll_cnt, '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
  endtask

  initial begin
    logic pend_a, pend_b;
    @(negedge clk);
    do_reset();
    chk("rst_rdata_a", rdata_a, '0);
    chk("rst_rdata_b", rdata_b, '0);

    // Preload every address so later reads never see unknowns.
    for (int i = 0; i < DEPTH / 2; i++) begin
      drive(1'b1, 1'b1, AW'(i), WIDTH'($urandom), 1'b1, 1'b1, AW'(i + DEPTH / 2), WIDTH'($urandom));
      step();
    end
    idle(); step();

    // 1: write then read on A
    drive(1'b1, 1'b1, 6'd3, 8'hA5, 1'b0, 1'b0, '0, '0); step();
    drive(1'b1, 1'b0, 6'd3, '0, 1'b0, 1'b0, '0, '0); step();
    chk("t1_rdata_a", rdata_a, 8'hA5);
    idle(); step();

    // 2: parallel writes to different addresses, then cross reads
    drive(1'b1, 1'b1, 6'd5, 8'h11, 1'b1, 1'b1, 6'd9, 8'h22); step();
    drive(1'b1, 1'b0, 6'd9, '0, 1'b1, 1'b0, 6'd5, '0); step();
    chk("t2_rdata_a", rdata_a, 8'h22);
    chk("t2_rdata_b", rdata_b, 8'h11);
    chk("t2_cnt", coll_cnt, 16'd0);

    // 3: write-write collision on address 7, A first then B
    drive(1'b1, 1'b1, 6'd7, 8'h3C, 1'b1, 1'b1, 6'd7, 8'hC3); step();
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 6'd7, 8'hC3); step();
    drive(1'b1, 1'b0, 6'd7, '0, 1'b0, 1'b0, '0, '0); step();
    chk("t3_rdata_a", rdata_a, 8'hC3);
    chk("t3_cnt", coll_cnt, 16'd1);

    // 4: read-read same address is not a collision
    drive(1'b1, 1'b0, 6'd7, '0, 1'b1, 1'b0, 6'd7, '0); step();
    chk("t4_equal", rdata_a, rdata_b);
    chk("t4_cnt", coll_cnt, 16'd1);
    idle(); step();

    // 5: continuous write collisions from rr = 0
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 6'd0, WIDTH'(8'h50 + i), 1'b1, 1'b1, 6'd0, WIDTH'(8'h60 + i));
      step();
    end
    chk("t5_cnt", coll_cnt, 16'd6);
    drive(1'b1, 1'b0, 6'd0, '0, 1'b0, 1'b0, '0, '0); step();
    chk("t5_rdata_a", rdata_a, 8'h65);

    // Random traffic over a few addresses; ungranted requests are held.
    pend_a = 1'b0; pend_b = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!pend_a) begin
        req_a = ($urandom_range(0, 9) < 7); we_a = $urandom_range(0, 1);
        addr_a = AW'($urandom_range(0, 3)); wdata_a = WIDTH'($urandom);
      end
      if (!pend_b) begin
        req_b = ($urandom_range(0, 9) < 7); we_b = $urandom_range(0, 1);
        addr_b = AW'($urandom_range(0, 3)); wdata_b = WIDTH'($urandom);
      end
      step();
      pend_a = req_a && !eg_a;
      pend_b = req_b && !eg_b;
    end
    idle(); step();

    // 6: read accepted, then async reset before the response cycle ends
    drive(1'b1, 1'b0, 6'd2, '0, 1'b0, 1'b0, '0, '0);
    step_edge();
    #2;
    rst_n = 1'b0;
    clr_model();
    #1;
    chk("t6_rvalid_a", rvalid_a, 1'b0);
    chk("t6_rdata_a", rdata_a, '0);
    chk("t6_cnt", coll_cnt, '0);
    chk("t6_gnt_a", gnt_a, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    step();
    // rr must be back at A
    drive(1'b1, 1'b1, 6'd4, 8'h77, 1'b1, 1'b1, 6'd4, 8'h88); step();
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 6'd4, 8'h88); step();
    drive(1'b1, 1'b0, 6'd4, '0, 1'b0, 1'b0, '0, '0); step();
    chk("t6_rdata_a", rdata_a, 8'h88);
    idle(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
